load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory access stage sitting directly downstream of the multicycle control unit's MEMADR/MEMREAD/MEMWRITE states.
- Takes the ALU-computed effective address, rs2 store data and funct3, and runs one req/ack transaction on the data bus.
- Generates byte strobes and replicated store data, and returns sign/zero-extended load data to the register-writeback mux.
- Flags misaligned or unsupported accesses and bus timeouts, and holds the core in its memory state through a busy/done handshake.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for bus_ack before aborting; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request pulse from the control unit
is_store  in  1  1 = store, 0 = load
funct3  in  3  RISC-V width/sign code
addr  in  32  effective byte address
store_data  in  32  rs2 value
load_data  out  32  extended load result, registered
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
fault  out  1  valid with done: misaligned, unsupported funct3, or timeout
bus_req  out  1  bus request, held until ack
bus_we  out  1  write enable
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_wstrb  out  4  byte strobes, 0 for loads
bus_wdata  out  32  aligned write data
bus_ack  in  1  bus completion, may arrive in the same cycle as bus_req
bus_rdata  in  32  read word, valid when bus_ack=1

Behaviour:
- Reset (reset=0 at a clock edge) is synchronous. It forces state IDLE, sets load_data, bus_addr, bus_wdata and the timeout counter to 0, and drives busy, done, fault, bus_req, bus_we and bus_wstrb to 0.
- Reset asserted mid-transaction drops bus_req immediately and abandons the access. No done pulse is produced.
- All inputs are captured on the start cycle. start is ignored while busy=1.
- FSM states:
  - IDLE: on start, check the access.
    - If it is illegal, go to RESP with fault pending.
    - Otherwise go to REQ with bus_req=1 and the registered bus fields.
  - REQ: bus_req=1.
    - bus_ack=1: capture bus_rdata and go to RESP.
    - Counter reaches TIMEOUT_CYCLES (non-zero) with no ack: go to RESP with fault pending and bus_req=0.
  - RESP: done=1 for one cycle, fault as determined, then go to IDLE.
- busy=1 in REQ and RESP.
- Latency: start at cycle t; earliest ack at t+1; done at t+2. Each extra wait cycle adds 1.
- Illegal-access latency: done at t+1 with fault=1 and no bus activity.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is unsupported, which is a fault.
- Misalignment is a fault:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- Store formatting (bus_we=1):
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=sd, wstrb=4'b1111.
- Load extraction:
  - shifted = rdata>>(8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
  - load_data updates in RESP only for successful loads, and holds otherwise.
- Store completion and any fault leave load_data unchanged.
- bus_ack outside REQ is ignored.
- The timeout counter clears on entering REQ.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM encoding LSU_IDLE=2'd0, LSU_REQ=2'd1, LSU_RESP=2'd2.
  - Legal/misaligned check function.
- One combinational sub-module, `lsu_align`, takes funct3, addr[1:0], store_data and rdata. It produces wstrb, wdata, the extended load value and the illegal flag.
- The FSM and registers stay in the top module.

Test Plan:
1. SW addr=0x100, sd=0xDEADBEEF, ack on first REQ cycle → bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done at t+2, fault=0.
2. LB addr=0x203, rdata=0x80FF_1234 → load_data=0xFFFFFF80. Same access as LBU → 0x00000080.
3. SH addr=0x102, sd=0x0000ABCD → wstrb=1100, wdata=0xABCDABCD. LH addr=0x101 → fault=1 at t+1, bus_req never asserted, load_data unchanged.
4. LW with 3 wait cycles, then ack with rdata=0x12345678 → busy held, done at t+5, load_data=0x12345678. A second start pulsed during REQ is ignored.
5. TIMEOUT_CYCLES=4, no ack → bus_req high 4 cycles then drops, done with fault=1. A later normal LW succeeds.
6. Reset pulled low during REQ → next cycle bus_req=0, busy=0, no done pulse. Unsupported store funct3=011 → fault, wstrb stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the legality check applied to every access before it reaches the bus.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // Unsupported width codes (including unsigned stores) and misalignment both fault.
  function automatic logic lsu_illegal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data, load extraction with
// sign/zero extension, and the illegal-access flag.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    wstrb    = 4'b0000;
    wdata    = store_data;
    load_ext = shifted;
    case (funct3)
      F3_B: begin
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        wstrb    = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        load_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        wstrb    = 4'b1111;
        load_ext = rdata;
      end
      F3_BU:   load_ext = {24'b0, shifted[7:0]};
      F3_HU:   load_ext = {16'b0, shifted[15:0]};
      default: ;
    endcase
    if (!is_store) wstrb = 4'b0000;
    illegal = lsu_illegal(is_store, funct3, addr_lo);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack bus transaction per start pulse, with
// fault reporting for illegal accesses and bus timeouts.
//
// state    | meaning
// LSU_IDLE | waiting for start; access checked on the start cycle
// LSU_REQ  | bus_req held until bus_ack or timeout
// LSU_RESP | one-cycle done pulse, fault valid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic             is_store_q, fault_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] cnt_q;

  logic        in_idle, timed_out;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata, a_load;
  logic        a_illegal;

  assign in_idle   = (state_q == LSU_IDLE);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !bus_ack;

  // Live inputs are decoded on the start cycle; captured fields during the access.
  lsu_align u_align (
    .is_store   (in_idle ? is_store   : is_store_q),
    .funct3     (in_idle ? funct3     : f3_q),
    .addr_lo    (in_idle ? addr[1:0]  : lo_q),
    .store_data (store_data),
    .rdata      (bus_rdata),
    .wstrb      (a_wstrb),
    .wdata      (a_wdata),
    .load_ext   (a_load),
    .illegal    (a_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (start) state_d = a_illegal ? LSU_RESP : LSU_REQ;
      LSU_REQ:  if (bus_ack || timed_out) state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wstrb = 4'b0000;
    if (reset) begin
      case (state_q)
        LSU_REQ: begin
          busy      = 1'b1;
          bus_req   = 1'b1;
          bus_we    = is_store_q;
          bus_wstrb = wstrb_q;
        end
        LSU_RESP: begin
          busy  = 1'b1;
          done  = 1'b1;
          fault = fault_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      wstrb_q    <= 4'b0000;
      cnt_q      <= '0;
      load_data  <= 32'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
    end else begin
      case (state_q)
        LSU_IDLE: if (start) begin
          is_store_q <= is_store;
          f3_q       <= funct3;
          lo_q       <= addr[1:0];
          fault_q    <= a_illegal;
          cnt_q      <= '0;
          if (!a_illegal) begin
            bus_addr <= {addr[31:2], 2'b00};
            wstrb_q  <= a_wstrb;
            if (is_store) bus_wdata <= a_wdata;
          end
        end
        LSU_REQ: begin
          if (bus_ack) begin
            fault_q <= 1'b0;
            if (!is_store_q) load_data <= a_load;
          end else if (timed_out) begin
            fault_q <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// random transactions compared against a behavioural model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        busy, done, fault, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ld_model = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .busy(busy),
    .done(done), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_illegal(input bit st, input logic [2:0] f3, input logic [1:0] lo);
    int size;
    if (st) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    else    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    if (size == 0) return 1'b1;
    return (int'(lo) % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> (8 * int'(lo));
    case (f3)
      3'd0:    return ((w & 32'hFF) ^ 32'h80) - 32'h80;
      3'd1:    return ((w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd4:    return w & 32'hFF;
      3'd5:    return w & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input bit st, input logic [2:0] f3, input logic [1:0] lo);
    int size;
    if (!st) return 4'b0000;
    size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    return 4'(((1 << size) - 1) << int'(lo));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 0) return (sd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  // d = number of REQ cycles without ack before ack; d >= TO means no ack at all.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int d, input bit poke);
    bit ill, exp_fault;
    int exp_lat, reqs, cyc;
    ill       = model_illegal(st, f3, a[1:0]);
    exp_fault = ill || (d >= TO);
    exp_lat   = ill ? 0 : ((d < TO) ? d + 1 : TO);
    reqs = 0;
    cyc  = 0;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; bus_ack = 1'b0;
    @(negedge clk);
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom;
    while (done !== 1'b1 && cyc < 40) begin
      if (bus_req === 1'b1) begin
        if (reqs == 0) begin
          check_eq("bus_addr", bus_addr, {a[31:2], 2'b00});
          check_eq("bus_we", bus_we, st);
          check_eq("bus_wstrb", bus_wstrb, model_wstrb(st, f3, a[1:0]));
          if (st) check_eq("bus_wdata", bus_wdata, model_wdata(f3, sd));
        end
        check_eq("busy_req", busy, 1'b1);
        bus_ack   = (reqs == d);
        bus_rdata = bus_ack ? rd : $urandom;
        reqs++;
        if (poke && reqs == 1) start = 1'b1;
      end else begin
        bus_ack = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check_eq("done_latency", cyc, exp_lat);
    check_eq("req_cycles", reqs, ill ? 0 : ((d < TO) ? d + 1 : TO));
    check_eq("fault", fault, exp_fault);
    check_eq("resp_wstrb", bus_wstrb, 4'b0000);
    if (!exp_fault && !st) ld_model = model_load(f3, a[1:0], rd);
    bus_ack = 1'($urandom);
    @(negedge clk);
    check_eq("done_pulse", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("load_data", load_data, ld_model);
    bus_ack = 1'b0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_pre_req", bus_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_bus_req", bus_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_load_data", load_data, 32'h0);
    ld_model = 32'h0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'($urandom);
      @(negedge clk);
      check_eq("rst_no_done", done, 1'b0);
      check_eq("rst_no_req", bus_req, 1'b0);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_bus_req", bus_req, 1'b0);
    check_eq("reset_wstrb", bus_wstrb, 4'b0000);
    check_eq("reset_load_data", load_data, 32'h0);
    check_eq("reset_bus_wdata", bus_wdata, 32'h0);
    reset = 1'b1;

    run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    check_eq("sw_wdata_const", bus_wdata, 32'hDEADBEEF);
    run_txn(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check_eq("lb_const", load_data, 32'hFFFFFF80);
    run_txn(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check_eq("lbu_const", load_data, 32'h00000080);
    run_txn(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 0, 1'b0);
    check_eq("sh_wdata_const", bus_wdata, 32'hABCDABCD);
    run_txn(1'b0, 3'd1, 32'h101, 32'h0, 32'h5555_5555, 0, 1'b0);
    check_eq("lh_mis_hold", load_data, 32'h00000080);
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 3, 1'b1);
    check_eq("lw_wait_const", load_data, 32'h12345678);
    run_txn(1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 10, 1'b0);
    check_eq("timeout_hold", load_data, 32'h12345678);
    run_txn(1'b0, 3'd2, 32'h308, 32'h0, 32'hA5A5_0F0F, 0, 1'b0);
    check_eq("after_timeout_lw", load_data, 32'hA5A5_0F0F);
    reset_mid();
    run_txn(1'b1, 3'd3, 32'h400, 32'h11223344, 32'h0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      run_txn(1'($urandom), f3, $urandom, $urandom, $urandom,
              $urandom_range(0, 5), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
